// File: rtl/sdr_dsp_pkg.sv
// Shared DSP definitions for the CIC compensation chain: FSM states, accumulator
// sizing, the default inverse-sinc^5 coefficient ROM and the round/saturate helper.
package sdr_dsp_pkg;

    localparam int DEF_COEF_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    function automatic int acc_width(input int ntaps, input int coef_w);
        return 8 + coef_w + $clog2(ntaps);
    endfunction

    // 16-tap symmetric compensator, sum 2048; alternating side lobes lift the CIC droop
    function automatic logic signed [DEF_COEF_W-1:0] comp_coef(input int k);
        int idx;
        logic signed [DEF_COEF_W-1:0] c;
        idx = k % 16;
        if (idx > 7) begin
            idx = 15 - idx;
        end else begin
            idx = idx;
        end
        case (idx)
            0:       c = -12'sd1;
            1:       c = 12'sd3;
            2:       c = -12'sd6;
            3:       c = 12'sd12;
            4:       c = -12'sd22;
            5:       c = 12'sd42;
            6:       c = -12'sd96;
            7:       c = 12'sd1092;
            default: c = 12'sd0;
        endcase
        return c;
    endfunction

    function automatic logic signed [47:0] round_sat(input logic signed [47:0] acc,
                                                     input int shift, input int out_w);
        logic signed [47:0] r;
        logic signed [47:0] hi;
        logic signed [47:0] lo;
        if (shift > 0) begin
            r = (acc + (48'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            r = acc;
        end
        hi = (48'sd1 <<< (out_w - 1)) - 48'sd1;
        lo = -(48'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/comp_mac.sv
// Multiply-accumulate datapath of the compensating FIR: one tap product per cycle,
// then round-half-up, shift and saturate into the registered output.
module comp_mac
    import sdr_dsp_pkg::*;
#(
    parameter int NTAPS  = 16,
    parameter int COEF_W = DEF_COEF_W,
    parameter int SHIFT  = 3,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     out_en,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [7:0]        sample,
    output logic signed [OUT_W-1:0]  d_out,
    output logic                     d_valid
);
    localparam int AW  = acc_width(NTAPS, COEF_W);
    localparam int PRW = 8 + COEF_W;

    logic signed [PRW-1:0] prod_s;
    logic signed [AW-1:0]  acc_r;

    assign prod_s = PRW'(sample) * PRW'(coef);

    // Accumulator and output register; reset abandons any partial sum
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r   <= {AW{1'b0}};
            d_out   <= {OUT_W{1'b0}};
            d_valid <= 1'b0;
        end else begin
            d_valid <= out_en;
            if (clr) begin
                acc_r <= {AW{1'b0}};
            end else if (en) begin
                acc_r <= acc_r + AW'(prod_s);
            end else begin
                acc_r <= acc_r;
            end
            if (out_en) begin
                d_out <= OUT_W'(round_sat(48'(acc_r), SHIFT, OUT_W));
            end else begin
                d_out <= d_out;
            end
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// Compensating FIR decimator behind the CIC: captures samples on d_clk rising edges
// into a circular buffer and runs one time-multiplexed MAC pass per output.
module cic_comp_fir
    import sdr_dsp_pkg::*;
#(
    parameter int NTAPS  = 16,
    parameter int COEF_W = DEF_COEF_W,
    parameter int DECIM  = 2,
    parameter int SHIFT  = 3,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    d_clk,
    input  logic signed [7:0]       d_in,
    output logic signed [OUT_W-1:0] d_out,
    output logic                    d_valid,
    output logic                    busy,
    output logic                    overrun
);
    localparam int PW = $clog2(NTAPS);

    logic                    d_clk_q_r;
    logic                    armed_r;
    logic signed [7:0]       samp_buf_r [NTAPS];
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           newest_r;
    logic [PW-1:0]           k_r;
    logic [1:0]              phase_r;
    fir_state_e              state_r;
    fir_state_e              state_nxt_s;
    logic                    strobe_s;
    logic                    accept_s;
    logic                    start_s;
    logic                    acc_clr_s;
    logic                    acc_en_s;
    logic                    out_en_s;
    logic [PW-1:0]           rd_idx_s;
    logic signed [COEF_W-1:0] coef_s;

    // armed_r blocks a d_clk that was already high when reset released
    assign strobe_s = d_clk & ~d_clk_q_r & armed_r;
    assign accept_s = strobe_s & ~busy;
    assign start_s  = accept_s & (phase_r == 2'(DECIM - 1));
    assign rd_idx_s = newest_r - k_r;
    assign coef_s   = COEF_W'(comp_coef(int'(k_r)));

    // Edge detect, sample buffer, write pointer, decimation phase and overrun flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_clk_q_r <= 1'b0;
            armed_r   <= 1'b0;
            wr_ptr_r  <= {PW{1'b0}};
            newest_r  <= {PW{1'b0}};
            phase_r   <= 2'd0;
            overrun   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                samp_buf_r[i] <= 8'sd0;
            end
        end else begin
            d_clk_q_r <= d_clk;
            armed_r   <= armed_r | ~d_clk;
            overrun   <= overrun | (strobe_s & busy);
            if (accept_s) begin
                samp_buf_r[wr_ptr_r] <= d_in;
                newest_r             <= wr_ptr_r;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
                phase_r              <= (phase_r == 2'(DECIM - 1)) ? 2'd0 : phase_r + 2'd1;
            end
        end
    end

    // FSM state, tap counter and busy register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            k_r     <= {PW{1'b0}};
            busy    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            k_r     <= (state_r == ST_MAC) ? k_r + PW'(1) : {PW{1'b0}};
            busy    <= (state_nxt_s != ST_IDLE);
        end
    end

    // Next-state and MAC control decode
    always_comb begin
        state_nxt_s = state_r;
        acc_clr_s   = 1'b0;
        acc_en_s    = 1'b0;
        out_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_MAC;
                    acc_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_en_s = 1'b1;
                if (k_r == PW'(NTAPS - 1)) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_MAC;
                end
            end
            ST_OUT: begin
                out_en_s    = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    comp_mac #(
        .NTAPS  (NTAPS),
        .COEF_W (COEF_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr_s),
        .en      (acc_en_s),
        .out_en  (out_en_s),
        .coef    (coef_s),
        .sample  (samp_buf_r[rd_idx_s]),
        .d_out   (d_out),
        .d_valid (d_valid)
    );

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench: three filter instances (DECIM/SHIFT variants) share one
// stimulus stream and are checked against a direct convolution reference.
module tb_cic_comp_fir;

    logic              clk = 1'b0;
    logic              rst;
    logic              d_clk;
    logic signed [7:0] d_in;
    logic signed [15:0] a_out, b_out, c_out;
    logic              a_valid, b_valid, c_valid;
    logic              a_busy, b_busy, c_busy;
    logic              a_ovr, b_ovr, c_ovr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit ignore_b = 1'b0;

    int COEF [16] = '{-1, 3, -6, 12, -22, 42, -96, 1092, 1092, -96, 42, -22, 12, -6, 3, -1};
    int hist [$];
    int n_acc = 0;
    int exp_a [$], exp_b [$], exp_c [$];
    int cyc_a [$], cyc_b [$], cyc_c [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cic_comp_fir #(.NTAPS(16), .COEF_W(12), .DECIM(1), .SHIFT(0), .OUT_W(16)) u_a (
        .clk(clk), .rst(rst), .d_clk(d_clk), .d_in(d_in),
        .d_out(a_out), .d_valid(a_valid), .busy(a_busy), .overrun(a_ovr));
    cic_comp_fir #(.NTAPS(16), .COEF_W(12), .DECIM(2), .SHIFT(3), .OUT_W(16)) u_b (
        .clk(clk), .rst(rst), .d_clk(d_clk), .d_in(d_in),
        .d_out(b_out), .d_valid(b_valid), .busy(b_busy), .overrun(b_ovr));
    cic_comp_fir #(.NTAPS(16), .COEF_W(12), .DECIM(1), .SHIFT(3), .OUT_W(16)) u_c (
        .clk(clk), .rst(rst), .d_clk(d_clk), .d_in(d_in),
        .d_out(c_out), .d_valid(c_valid), .busy(c_busy), .overrun(c_ovr));

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Convolution of accepted history with the taps, then floor-rounding and clamping
    function automatic int expect_out(input int shift);
        longint acc = 0;
        longint num, dv, q;
        for (int k = 0; k < 16; k++) begin
            int idx = hist.size() - 1 - k;
            if (idx >= 0) acc += longint'(COEF[k]) * longint'(hist[idx]);
        end
        if (shift > 0) begin
            dv  = longint'(1) << shift;
            num = acc + dv / 2;
            q   = num / dv;
            if (num < 0 && (num % dv) != 0) q = q - 1;
        end else begin
            q = acc;
        end
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic model_accept(input int s, input int e);
        hist.push_back(s);
        n_acc++;
        exp_a.push_back(expect_out(0)); cyc_a.push_back(e + 17);
        exp_c.push_back(expect_out(3)); cyc_c.push_back(e + 17);
        if (n_acc % 2 == 0) begin
            exp_b.push_back(expect_out(3)); cyc_b.push_back(e + 17);
        end
    endtask

    task automatic clear_model();
        hist.delete(); n_acc = 0;
        exp_a.delete(); exp_b.delete(); exp_c.delete();
        cyc_a.delete(); cyc_b.delete(); cyc_c.delete();
    endtask

    // Called at a negedge; the strobe edge is the next posedge, next strobe 'gap' cycles later
    task automatic strobe(input int s, input int gap, input bit model);
        logic signed [7:0] sv;
        int e;
        sv = 8'(s);
        e = cyc + 1;
        d_in = sv;
        d_clk = 1'b1;
        if (model) model_accept(int'(sv), e);
        repeat (2) @(negedge clk);
        d_clk = 1'b0;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        clear_model();
        repeat (n) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain_check(input string tag);
        repeat (25) @(negedge clk);
        check_eq({tag, "_a_left"}, exp_a.size(), 0);
        check_eq({tag, "_c_left"}, exp_c.size(), 0);
        if (!ignore_b) check_eq({tag, "_b_left"}, exp_b.size(), 0);
    endtask

    // Scoreboard: every valid pops one expected value and its expected cycle
    always @(negedge clk) begin
        if (a_valid) begin
            if (exp_a.size() == 0) check_eq("a_spurious_valid", a_valid, 0);
            else begin
                check_eq("a_out", a_out, exp_a.pop_front());
                check_eq("a_latency", cyc, cyc_a.pop_front());
            end
        end
        if (c_valid) begin
            if (exp_c.size() == 0) check_eq("c_spurious_valid", c_valid, 0);
            else begin
                check_eq("c_out", c_out, exp_c.pop_front());
                check_eq("c_latency", cyc, cyc_c.pop_front());
            end
        end
        if (b_valid && !ignore_b) begin
            if (exp_b.size() == 0) check_eq("b_spurious_valid", b_valid, 0);
            else begin
                check_eq("b_out", b_out, exp_b.pop_front());
                check_eq("b_latency", cyc, cyc_b.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; d_clk = 1'b0; d_in = 8'sd0;
        repeat (3) @(negedge clk);
        check_eq("rst_a_out", a_out, 0);
        check_eq("rst_a_valid", a_valid, 0);
        check_eq("rst_a_busy", a_busy, 0);
        check_eq("rst_a_overrun", a_ovr, 0);
        check_eq("rst_b_out", b_out, 0);
        check_eq("rst_c_out", c_out, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Impulse: a gives the raw taps, c the rounded taps, b every second output
        strobe(1, 32, 1'b1);
        repeat (16) strobe(0, 32, 1'b1);
        drain_check("impulse");

        // DC level 64 settles to 16384 on the decimating instance
        repeat (40) strobe(64, 20, 1'b1);
        drain_check("dc");

        // Full-scale inputs at the minimum legal strobe spacing
        repeat (24) strobe(127, 18, 1'b1);
        repeat (24) strobe(-128, 18, 1'b1);
        drain_check("sat");
        check_eq("sat_a_overrun", a_ovr, 0);
        check_eq("sat_b_overrun", b_ovr, 0);

        repeat (60) strobe(int'($urandom_range(0, 255)) - 128, int'($urandom_range(18, 25)), 1'b1);
        drain_check("random");

        // Overrun: three strobes land while busy and must be discarded
        do_reset(2);
        ignore_b = 1'b1;
        strobe(1, 5, 1'b1);
        check_eq("ovr_before_drop", a_ovr, 0);
        strobe(99, 5, 1'b0);
        check_eq("ovr_after_drop", a_ovr, 1);
        check_eq("ovr_busy", a_busy, 1);
        strobe(99, 5, 1'b0);
        strobe(99, 5, 1'b0);
        repeat (3) strobe(0, 32, 1'b1);
        check_eq("ovr_sticky_a", a_ovr, 1);
        check_eq("ovr_sticky_c", c_ovr, 1);
        drain_check("overrun");

        // Reset at E+8 abandons the pass; no valid and cleared state afterwards
        d_in = 8'sd1; d_clk = 1'b1;
        @(negedge clk);
        check_eq("mid_busy", a_busy, 1);
        @(negedge clk);
        d_clk = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        ignore_b = 1'b0;
        check_eq("mid_a_out", a_out, 0);
        check_eq("mid_a_valid", a_valid, 0);
        check_eq("mid_a_busy", a_busy, 0);
        check_eq("mid_a_overrun", a_ovr, 0);
        repeat (30) @(negedge clk);
        strobe(1, 32, 1'b1);
        repeat (16) strobe(0, 32, 1'b1);
        drain_check("post_reset");

        // d_clk held high through reset must not count as a rising edge
        d_clk = 1'b1;
        rst = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("hi_after_rst_busy", a_busy, 0);
        d_clk = 1'b0;
        repeat (2) @(negedge clk);
        strobe(5, 32, 1'b1);
        strobe(-7, 32, 1'b1);
        drain_check("hi_after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Compensating FIR decimator directly downstream of the 5-stage CIC decimator. Consumes the CIC's signed 8-bit output and its `d_clk` sample clock, flattens the CIC passband droop, and optionally decimates further. Uses one time-multiplexed multiply-accumulate over a circular sample buffer. Emits a wider signed result with a one-cycle valid strobe for the demodulator.

## Interface
- `NTAPS`, 16: number of taps, power of two, 8..64.
- `COEF_W`, 12: signed coefficient width.
- `DECIM`, 2: extra decimation factor, 1..4. 1 means an output for every input sample.
- `SHIFT`, 3: arithmetic right shift applied before output rounding, 0..(accumulator width − OUT_W).
- `OUT_W`, 16: output width.
- `clk`  in  1  system clock, the same clock as the CIC.
- `rst`  in  1  one clock; reset is synchronous and active-low (`rst`=0 resets on the next `clk` edge).
- `d_clk`  in  1  CIC sample clock (level). Its rising edge marks a new `d_in`.
- `d_in`  in  8  signed sample from the CIC.
- `d_out`  out  OUT_W  signed filtered sample. Held between strobes.
- `d_valid`  out  1  one-cycle pulse when `d_out` updates.
- `busy`  out  1  high while the MAC is running.
- `overrun`  out  1  sticky flag: a sample arrived while `busy`. Cleared only by reset.

## Operation
- **Edge detect:** `d_clk` is registered into `d_clk_q`. `strobe = d_clk & ~d_clk_q`.
- **Accepted strobe (`busy`=0):**
  - `d_in` is written to `buf[wr_ptr]`, and `newest` ← `wr_ptr`.
  - `wr_ptr` ← (`wr_ptr`+1) mod NTAPS.
  - `phase` ← (`phase`+1) mod DECIM.
  - If the old `phase` was DECIM−1 (always true when DECIM=1), the FSM starts.
- **Strobe while `busy`:** the sample is dropped. Buffer, pointers and `phase` are unchanged, and `overrun` ← 1.
- **FSM states:**
  - IDLE → MAC on start: `acc` ← 0, `k` ← 0.
  - MAC, one tap per cycle: `acc += COEF[k] * buf[(newest − k) mod NTAPS]`. When `k`=NTAPS−1, go to OUT.
  - OUT: compute `d_out`, pulse `d_valid`, go to IDLE.
- **Arithmetic:**
  - Product width: 8+COEF_W.
  - `acc` width: 8+COEF_W+log2(NTAPS). It cannot overflow.
  - If SHIFT>0, add 2^(SHIFT−1), then arithmetic shift right by SHIFT (round half up).
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- **Reset values:**
  - Outputs: `d_out`=0, `d_valid`=0, `busy`=0, `overrun`=0.
  - Internal: `buf` all zero, `wr_ptr`=0, `phase`=0, `d_clk_q`=0, FSM=IDLE.
- **Reset mid-MAC:** the computation is abandoned and no `d_valid` is issued.
- **After reset:** a `d_clk` that is already high does not produce a strobe. The first strobe requires a low-to-high transition.

## Timing
- Edge E is the first edge at which `d_clk`=1 with `d_clk_q`=0.
- The sample is written at E. `busy` rises at E, and the FSM is in MAC from E+1 through E+NTAPS.
- OUT is at E+NTAPS+1, where `d_out` and `d_valid` register. `busy` falls at the same edge.
- Latency from strobe to `d_valid` is NTAPS+1 cycles (17 at defaults).
- Required strobe spacing is at least NTAPS+2 cycles. The CIC ratio satisfies this (decimation_ratio ≥ 18 at defaults). Any closer strobe sets `overrun`.
- A strobe at the same edge as OUT is dropped, because `busy` is still 1.
- `wr_ptr` wraps NTAPS−1 → 0 with no special case.

## Structure
- **Package `sdr_dsp_pkg`:**
  - `COEF_W` default and the accumulator-width function.
  - Coefficient ROM function `comp_coef(k)` for the default 16 taps: symmetric, sum = 2048, inverse-sinc⁵ shaped.
  - Saturate/round helper function.
- **Sub-module `comp_mac`:** owns the multiplier, accumulator, and the round/saturate stage. The top level owns the edge detect, buffer, pointers, `phase` and the FSM.

## Test plan
- **Impulse, DECIM=1, SHIFT=0:**
  - Stimulus: one sample 1, then zeros, strobes every 32 cycles.
  - Required: `d_out` sequence equals `comp_coef(0..15)`, then 0.
  - Required: each `d_valid` occurs exactly 17 cycles after its strobe edge.
- **DC, DECIM=2, SHIFT=3:**
  - Stimulus: constant `d_in`=64.
  - Required: after 16 samples, every `d_out`=16384, with one `d_valid` per 2 strobes.
- **Saturation, SHIFT=0:**
  - Constant 127 → `d_out`=32767.
  - Constant −128 → `d_out`=−32768.
  - No wrap to the opposite sign in either case.
- **Overrun:**
  - Stimulus: strobes 5 cycles apart.
  - Required: `overrun`=1 from the dropped strobe onward; the dropped sample is not written to the buffer; the flag persists until `rst`=0.
- **Reset mid-MAC:**
  - Stimulus: assert `rst`=0 at E+8 for one cycle.
  - Required: no `d_valid`, `d_out`=0, `buf` cleared.
  - Required: the next impulse reproduces the first test's output.
- **Rounding, SHIFT=3:**
  - Stimulus: impulse of 1 with DECIM=1.
  - Required: each output = floor((coef+4)/8).
